// File: rtl/layer_engine_config_slave.sv
// rtl/layer_engine_config_slave.sv - responder end of the layer engine config bus with register bank
//
// Purpose: decodes single-outstanding write/read requests from the layer engine
// controller into a bank of C_NUM_REGS registers of C_DATA_WIDTH bits each.
//   idx 0  CONTROL: read/write; bit 0 is a self-clearing start strobe and always reads 0.
//   idx 1  STATUS : bit 0 shows live engine_busy, bit 1 is sticky done, bit 2 is sticky
//                   address error. Writing 1 to bit 1 or bit 2 clears it; if a set event
//                   lands in the same cycle, the bit stays set.
//   idx 2+ plain read/write registers.
// The whole bank is exported flat on cfg_regs; the STATUS slot carries the live value.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   config_address           register address (bank spans BASE..BASE+C_NUM_REGS-1)
//   config_wren/config_rden  requests, held by the master until acked
//   config_datain            write data
//   config_wrack             1-cycle write ack, 1 cycle after accept
//   config_rdack             1-cycle read ack, C_RD_LATENCY cycles after accept
//   config_dataout           read data, held until the next read ack
//   engine_busy, engine_done status inputs from the datapath
//   engine_start             1-cycle pulse after a CONTROL write with bit 0 set
//   cfg_regs                 flat bank contents, reg i at [i*W +: W]

module layer_engine_config_slave #(
  parameter int                      C_DATA_WIDTH = 128,
  parameter int                      C_ADDR_WIDTH = 16,
  parameter int                      C_NUM_REGS   = 16,
  parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = '0,
  parameter int                      C_RD_LATENCY = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [C_ADDR_WIDTH-1:0]            config_address,
  input  logic                               config_wren,
  input  logic                               config_rden,
  input  logic [C_DATA_WIDTH-1:0]            config_datain,
  output logic                               config_wrack,
  output logic                               config_rdack,
  output logic [C_DATA_WIDTH-1:0]            config_dataout,
  input  logic                               engine_busy,
  input  logic                               engine_done,
  output logic                               engine_start,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] cfg_regs
);

  localparam int                      IDX_W    = $clog2(C_NUM_REGS);
  localparam logic [C_ADDR_WIDTH-1:0] NUM_REGS = C_ADDR_WIDTH'(C_NUM_REGS);
  localparam logic [C_DATA_WIDTH-1:0] BIT0     = C_DATA_WIDTH'(1);
  localparam logic [IDX_W-1:0]        IDX_CTRL = IDX_W'(0);
  localparam logic [IDX_W-1:0]        IDX_STAT = IDX_W'(1);

  typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT, RD_ACK} state_t;

  state_t                   state;
  logic [2:0]               lat_cnt;
  logic [C_DATA_WIDTH-1:0]  bank [C_NUM_REGS];
  logic [C_DATA_WIDTH-1:0]  rd_buf;
  logic                     done_q;
  logic                     err_q;

  logic [C_ADDR_WIDTH-1:0]  offset;
  logic                     hit;
  logic [IDX_W-1:0]         idx;
  logic [C_DATA_WIDTH-1:0]  status_val;
  logic [C_DATA_WIDTH-1:0]  rd_value;
  logic                     accept_wr;
  logic                     accept_rd;
  logic                     miss;
  logic                     wr_ctrl;
  logic                     wr_stat;
  logic                     done_clr;
  logic                     err_clr;

  // Unsigned subtraction makes addresses below the base wrap high and miss.
  always_comb begin
    offset     = config_address - C_BASE_ADDR;
    hit        = offset < NUM_REGS;
    idx        = offset[IDX_W-1:0];
    status_val = {{(C_DATA_WIDTH-3){1'b0}}, err_q, done_q, engine_busy};

    accept_wr  = (state == IDLE) && config_wren;
    accept_rd  = (state == IDLE) && !config_wren && config_rden;
    miss       = (accept_wr || accept_rd) && !hit;
    wr_ctrl    = accept_wr && hit && (idx == IDX_CTRL);
    wr_stat    = accept_wr && hit && (idx == IDX_STAT);
    done_clr   = wr_stat && config_datain[1];
    err_clr    = wr_stat && config_datain[2];

    rd_value = '0;
    if (hit) begin
      if (idx == IDX_STAT) rd_value = status_val;
      else                 rd_value = bank[idx];
    end
  end

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_flat
    if (i == 1) begin : g_stat
      assign cfg_regs[i*C_DATA_WIDTH +: C_DATA_WIDTH] = status_val;
    end else begin : g_reg
      assign cfg_regs[i*C_DATA_WIDTH +: C_DATA_WIDTH] = bank[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      config_wrack   <= 1'b0;
      config_rdack   <= 1'b0;
      config_dataout <= '0;
      engine_start   <= 1'b0;
      rd_buf         <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      for (int i = 0; i < C_NUM_REGS; i++) bank[i] <= '0;
    end else begin
      config_wrack <= 1'b0;
      config_rdack <= 1'b0;
      engine_start <= wr_ctrl && config_datain[0];
      // Set terms are ORed after the clear so a coincident event wins.
      done_q       <= engine_done | (done_q & ~done_clr);
      err_q        <= miss | (err_q & ~err_clr);

      case (state)
        IDLE: begin
          if (accept_wr) begin
            if (hit && (idx != IDX_STAT)) begin
              if (idx == IDX_CTRL) bank[idx] <= config_datain & ~BIT0;
              else                 bank[idx] <= config_datain;
            end
            config_wrack <= 1'b1;
            state        <= WR_ACK;
          end else if (accept_rd) begin
            rd_buf <= rd_value;
            if (C_RD_LATENCY == 1) begin
              config_rdack   <= 1'b1;
              config_dataout <= rd_value;
              state          <= RD_ACK;
            end else begin
              lat_cnt <= 3'(C_RD_LATENCY - 1);
              state   <= RD_WAIT;
            end
          end
        end
        WR_ACK: state <= IDLE;
        RD_WAIT: begin
          if (lat_cnt == 3'd1) begin
            config_rdack   <= 1'b1;
            config_dataout <= rd_buf;
            state          <= RD_ACK;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RD_ACK:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
